// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file writeback path.
package rf_pkg;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    typedef struct packed {
        logic            live;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/rf_wb_buffer.sv
// In-order buffer of load results waiting for the register-file write port.
// Entries can be squashed in place; they keep their slot until popped.
module rf_wb_buffer
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [AW-1:0]                i_push_rd,
    input  logic [XLEN-1:0]              i_push_data,
    input  logic                         i_pop,
    input  logic                         i_squash_en,
    input  logic [AW-1:0]                i_squash_rd,
    output wb_entry_t                    o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [NREGS-1:0]             o_pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // Popped slots have live cleared, so live alone marks buffered writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_squash_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_mem[i].rd == i_squash_rd) begin
                        r_mem[i].live <= 1'b0;
                    end
                end
            end
            if (i_pop) begin
                r_mem[r_rd_ptr].live <= 1'b0;
                r_rd_ptr             <= r_rd_ptr + 1'b1;
            end
            if (i_push) begin
                r_mem[r_wr_ptr] <= '{live: 1'b1, rd: i_push_rd, data: i_push_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live) begin
                o_pending[r_mem[i].rd] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_writeback_ctrl.sv
// Merges ALU and LSU results onto the single register-file write port.
// ALU results are always the youngest write and override buffered loads.
module rf_writeback_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         ALU_VALID,
    input  logic [AW-1:0]                ALU_RD,
    input  logic [XLEN-1:0]              ALU_DATA,
    input  logic                         LSU_VALID,
    output logic                         LSU_READY,
    input  logic [AW-1:0]                LSU_RD,
    input  logic [XLEN-1:0]              LSU_DATA,
    output logic [AW-1:0]                A3,
    output logic [XLEN-1:0]              WD3,
    output logic                         WE3,
    output logic [NREGS-1:0]             PENDING,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT
);
    wb_entry_t       w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_alu_issue;
    logic            w_lsu_acc;
    logic            w_lsu_nz;
    logic            w_pop;
    logic            w_head_issue;
    logic            w_bypass;
    logic            w_push;

    logic [AW-1:0]   r_a3;
    logic [XLEN-1:0] r_wd3;
    logic            r_we3;

    // READY depends only on the occupancy flop, never on this cycle's pop.
    assign LSU_READY    = ~w_full;
    assign w_lsu_acc    = LSU_VALID & ~w_full;
    assign w_lsu_nz     = (LSU_RD != '0);
    assign w_alu_issue  = ALU_VALID & (ALU_RD != '0);
    assign w_pop        = ~w_alu_issue & ~w_empty;
    assign w_head_issue = w_pop & w_head.live;
    assign w_bypass     = ~w_alu_issue & w_empty & w_lsu_acc & w_lsu_nz;
    assign w_push       = w_lsu_acc & w_lsu_nz & ~w_bypass
                        & ~(w_alu_issue & (LSU_RD == ALU_RD));

    rf_wb_buffer #(.DEPTH(DEPTH)) u_buf (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_push      (w_push),
        .i_push_rd   (LSU_RD),
        .i_push_data (LSU_DATA),
        .i_pop       (w_pop),
        .i_squash_en (w_alu_issue),
        .i_squash_rd (ALU_RD),
        .o_head      (w_head),
        .o_count     (COUNT),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_pending   (PENDING)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
        end else begin
            r_we3 <= w_alu_issue | w_head_issue | w_bypass;
            if (w_alu_issue) begin
                r_a3  <= ALU_RD;
                r_wd3 <= ALU_DATA;
            end else if (w_head_issue) begin
                r_a3  <= w_head.rd;
                r_wd3 <= w_head.data;
            end else if (w_bypass) begin
                r_a3  <= LSU_RD;
                r_wd3 <= LSU_DATA;
            end
        end
    end

    assign A3  = r_a3;
    assign WD3 = r_wd3;
    assign WE3 = r_we3;
endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench: expected register-file writes are queued at stimulus time
// and checked in order by a monitor whenever WE3 is high.
module tb_rf_writeback_ctrl;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [31:0] ALU_DATA;
    logic        LSU_VALID;
    logic        LSU_READY;
    logic [4:0]  LSU_RD;
    logic [31:0] LSU_DATA;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] PENDING;
    logic [2:0]  COUNT;

    rf_writeback_ctrl #(.DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
        .LSU_VALID(LSU_VALID), .LSU_READY(LSU_READY), .LSU_RD(LSU_RD), .LSU_DATA(LSU_DATA),
        .A3(A3), .WD3(WD3), .WE3(WE3), .PENDING(PENDING), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    logic [31:0] rf_shadow [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lsu_idx;
    logic        acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic exp_write(input logic [4:0] a, input logic [31:0] d);
        exp_t x;
        x.a = a;
        x.d = d;
        sb_q.push_back(x);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ALU_VALID = 1'b0; ALU_RD = '0; ALU_DATA = '0;
        LSU_VALID = 1'b0; LSU_RD = '0; LSU_DATA = '0;
    endtask

    task automatic drive_lsu3(input int idx);
        if (idx < 5) begin
            LSU_VALID = 1'b1;
            LSU_RD    = 5'(10 + idx);
            LSU_DATA  = 32'h200 + 32'(idx);
        end else begin
            LSU_VALID = 1'b0;
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && WE3 !== 1'b0) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got write A3=%0d WD3=0x%0h, expected no write", A3, WD3);
            end else begin
                e = sb_q.pop_front();
                if (A3 !== e.a || WD3 !== e.d) begin
                    n_fail++;
                    $display("FAIL sb_write: got A3=%0d WD3=0x%0h, expected A3=%0d WD3=0x%0h",
                             A3, WD3, e.a, e.d);
                end
            end
            rf_shadow[A3] = WD3;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_shadow[i] = '0;
        idle_inputs();
        RST_N = 1'b0;
        #13;
        chk("rst_we3", WE3, 0);
        chk("rst_a3", A3, 0);
        chk("rst_wd3", WD3, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_pending", PENDING, 0);
        cyc();
        RST_N = 1'b1;
        cyc();
        chk("rst_ready", LSU_READY, 1);

        // 1: ALU single write, then hold
        ALU_VALID = 1'b1; ALU_RD = 5'd5; ALU_DATA = 32'h1234;
        exp_write(5'd5, 32'h1234);
        cyc();
        chk("t1_we3", WE3, 1);
        idle_inputs();
        cyc();
        chk("t1_we3_drop", WE3, 0);
        chk("t1_a3_hold", A3, 5);
        chk("t1_wd3_hold", WD3, 32'h1234);

        // 2: LSU bypass into empty buffer
        LSU_VALID = 1'b1; LSU_RD = 5'd7; LSU_DATA = 32'hAA;
        exp_write(5'd7, 32'hAA);
        cyc();
        idle_inputs();
        chk("t2_count", COUNT, 0);
        chk("t2_a3", A3, 7);
        cyc();

        // 3: ALU busy fills the buffer; loads drain in order afterwards
        lsu_idx = 0;
        for (int k = 0; k < 6; k++) begin
            ALU_VALID = 1'b1; ALU_RD = 5'(k + 1); ALU_DATA = 32'h100 + 32'(k);
            exp_write(5'(k + 1), 32'h100 + 32'(k));
            drive_lsu3(lsu_idx);
            acc = LSU_VALID & LSU_READY;
            cyc();
            if (acc) lsu_idx++;
        end
        chk("t3_count_full", COUNT, 4);
        chk("t3_ready_low", LSU_READY, 0);
        chk("t3_pending", PENDING, 32'h0000_3C00);
        chk("t3_fifth_held", lsu_idx, 4);
        ALU_VALID = 1'b0;
        for (int i = 0; i < 5; i++) exp_write(5'(10 + i), 32'h200 + 32'(i));
        for (int g = 0; g < 20 && lsu_idx < 5; g++) begin
            drive_lsu3(lsu_idx);
            acc = LSU_VALID & LSU_READY;
            cyc();
            if (acc) lsu_idx++;
        end
        chk("t3_fifth_accepted", lsu_idx, 5);
        idle_inputs();
        repeat (6) cyc();
        chk("t3_count_drained", COUNT, 0);
        chk("t3_pending_drained", PENDING, 0);
        chk("t3_sb_drained", sb_q.size(), 0);

        // 4: ALU write squashes an older buffered load to the same register
        ALU_VALID = 1'b1; ALU_RD = 5'd20; ALU_DATA = 32'h20;
        LSU_VALID = 1'b1; LSU_RD = 5'd3; LSU_DATA = 32'h11;
        exp_write(5'd20, 32'h20);
        cyc();
        ALU_RD = 5'd21; ALU_DATA = 32'h21;
        LSU_RD = 5'd4; LSU_DATA = 32'h44;
        exp_write(5'd21, 32'h21);
        cyc();
        chk("t4_pending_both", PENDING, 32'h18);
        chk("t4_count2", COUNT, 2);
        LSU_VALID = 1'b0;
        ALU_RD = 5'd3; ALU_DATA = 32'h22;
        exp_write(5'd3, 32'h22);
        cyc();
        chk("t4_pending_squash", PENDING, 32'h10);
        chk("t4_count_kept", COUNT, 2);
        idle_inputs();
        exp_write(5'd4, 32'h44);
        cyc();
        chk("t4_silent_pop_we3", WE3, 0);
        chk("t4_count1", COUNT, 1);
        cyc();
        chk("t4_count0", COUNT, 0);
        cyc();
        chk("t4_reg3", rf_shadow[3], 32'h22);
        chk("t4_reg4", rf_shadow[4], 32'h44);

        // 5: same-register collision and x0 writes
        ALU_VALID = 1'b1; ALU_RD = 5'd9; ALU_DATA = 32'h99;
        LSU_VALID = 1'b1; LSU_RD = 5'd9; LSU_DATA = 32'h77;
        chk("t5_ready", LSU_READY, 1);
        exp_write(5'd9, 32'h99);
        cyc();
        chk("t5_count", COUNT, 0);
        chk("t5_pending", PENDING, 0);
        ALU_RD = 5'd0; ALU_DATA = 32'hDEAD;
        LSU_RD = 5'd0; LSU_DATA = 32'hBEEF;
        cyc();
        chk("t5_x0_we3", WE3, 0);
        chk("t5_x0_count", COUNT, 0);
        idle_inputs();
        cyc();
        chk("t5_x0_a3_hold", A3, 9);

        // 6: reset mid-operation discards buffered loads
        for (int k = 0; k < 3; k++) begin
            ALU_VALID = 1'b1; ALU_RD = 5'(k + 1); ALU_DATA = 32'h300 + 32'(k);
            LSU_VALID = 1'b1; LSU_RD = 5'(15 + k); LSU_DATA = 32'h400 + 32'(k);
            if (k < 2) exp_write(5'(k + 1), 32'h300 + 32'(k));
            cyc();
        end
        chk("t6_pre_we3", WE3, 1);
        chk("t6_pre_count", COUNT, 3);
        idle_inputs();
        RST_N = 1'b0;
        #1;
        chk("t6_rst_we3", WE3, 0);
        chk("t6_rst_count", COUNT, 0);
        chk("t6_rst_pending", PENDING, 0);
        cyc();
        cyc();
        RST_N = 1'b1;
        repeat (8) cyc();
        chk("t6_post_count", COUNT, 0);
        chk("t6_post_ready", LSU_READY, 1);
        chk("t6_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
